// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM encoding and limits for the bit-serial arithmetic family
package serial_arith_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam int SERIAL_MAX_WIDTH = 64;
endpackage

// File: rtl/serial_sub_nb_if.sv
// serial_sub_nb_if: operand/result handshake bundle for serial_sub_nb
//   in_valid/in_ready + a/b  : operand channel (master -> slave)
//   out_valid/out_ready      : result channel (slave -> master)
//   diff/borrow/zero/ovf     : result payload, valid while out_valid
interface serial_sub_nb_if #(parameter int WIDTH = 8);
   logic in_valid, in_ready, out_valid, out_ready, borrow, zero, ovf;
   logic [WIDTH-1:0] a, b, diff;
   modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, diff, borrow, zero, ovf);
   modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, diff, borrow, zero, ovf);
endinterface

// File: rtl/fa_1b.sv
// fa_1b: 1-bit full adder
//   A, B, Cin : addend bits and carry in
//   S, Cout   : sum and carry out
module fa_1b (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);
   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_sub_nb.sv
// serial_sub_nb: bit-serial WIDTH-bit two's-complement subtractor (a - b), LSB first
//   clk, rst_n : clock, asynchronous active-low reset
//   io.slave   : in_valid/in_ready/a/b operand handshake,
//                out_valid/out_ready/diff/borrow/zero/ovf result handshake
module serial_sub_nb
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   serial_sub_nb_if.slave io
);
   localparam int CW = $clog2(WIDTH) > 0 ? $clog2(WIDTH) : 1;
   if (WIDTH < 2 || WIDTH > SERIAL_MAX_WIDTH) begin : g_bad_width
      $error("serial_sub_nb: WIDTH %0d outside 2..%0d", WIDTH, SERIAL_MAX_WIDTH);
   end
   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic [CW-1:0]    count;
   logic             carry, s, cout, last;
   // a - b = a + ~b + 1: invert the subtrahend bit and seed the carry with 1
   fa_1b u_fa (.A(a_sh[0]), .B(~b_sh[0]), .Cin(carry), .S(s), .Cout(cout));
   assign last         = count == CW'(WIDTH - 1);
   assign io.in_ready  = state == ST_IDLE;
   assign io.out_valid = state == ST_DONE;
   assign io.diff      = res;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         res       <= '0;
         count     <= '0;
         carry     <= 1'b0;
         io.borrow <= 1'b0;
         io.zero   <= 1'b0;
         io.ovf    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (io.in_valid) begin
               a_sh  <= io.a;
               b_sh  <= io.b;
               carry <= 1'b1;
               count <= '0;
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               res   <= {s, res[WIDTH-1:1]};
               carry <= cout;
               count <= count + 1'b1;
               // carry still holds the carry into the MSB here, so ovf is cin ^ cout of the sign bit
               if (last) begin
                  io.borrow <= ~cout;
                  io.ovf    <= carry ^ cout;
                  io.zero   <= ~|{s, res[WIDTH-1:1]};
                  state     <= ST_DONE;
               end
            end
            ST_DONE: if (io.out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_sub_nb.sv
// tb_serial_sub_nb: directed and randomized checks of serial_sub_nb at WIDTH=8 and WIDTH=4
module tb_serial_sub_nb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int lat;
   always #5 clk = ~clk;
   serial_sub_nb_if #(.WIDTH(8)) if8 ();
   serial_sub_nb_if #(.WIDTH(4)) if4 ();
   serial_sub_nb #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(if8.slave));
   serial_sub_nb #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(if4.slave));
   // reference: {ovf, zero, borrow, diff} from plain integer arithmetic
   function automatic logic [67:0] model(input int w, input longint a, input longint b);
      longint m = longint'(1) << w;
      longint h = longint'(1) << (w - 1);
      longint d = (a - b + m) % m;
      longint sa = a >= h ? a - m : a;
      longint sb = b >= h ? b - m : b;
      longint r = sa - sb;
      return {r >= h || r < -h, d == 0, a < b, 64'(d)};
   endfunction
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic out8(input string tag, input logic [7:0] a, input logic [7:0] b);
      logic [67:0] e = model(8, a, b);
      chk({tag, " diff"}, 64'(if8.diff), e[63:0]);
      chk({tag, " borrow"}, 64'(if8.borrow), 64'(e[64]));
      chk({tag, " zero"}, 64'(if8.zero), 64'(e[65]));
      chk({tag, " ovf"}, 64'(if8.ovf), 64'(e[66]));
   endtask
   task automatic out4(input string tag, input logic [3:0] a, input logic [3:0] b);
      logic [67:0] e = model(4, a, b);
      chk({tag, " diff"}, 64'(if4.diff), e[63:0]);
      chk({tag, " borrow"}, 64'(if4.borrow), 64'(e[64]));
      chk({tag, " zero"}, 64'(if4.zero), 64'(e[65]));
      chk({tag, " ovf"}, 64'(if4.ovf), 64'(e[66]));
   endtask
   // present operands at a falling edge; returns one falling edge after the accepting edge
   task automatic start8(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      if8.a = a;
      if8.b = b;
      if8.in_valid = 1'b1;
      while (!if8.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if8.in_valid = 1'b0;
      if8.a = 8'($urandom);
      if8.b = 8'($urandom);
      lat = 1;
   endtask
   // lat counts cycles after the handshake cycle; out_valid is due in cycle WIDTH+1
   task automatic wait8();
      while (!if8.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic do8(input string tag, input logic [7:0] a, input logic [7:0] b);
      start8(a, b);
      wait8();
      chk({tag, " latency"}, 64'(lat), 64'd9);
      out8(tag, a, b);
      @(negedge clk);
      chk({tag, " valid drop"}, 64'(if8.out_valid), 64'd0);
      chk({tag, " ready back"}, 64'(if8.in_ready), 64'd1);
   endtask
   initial begin
      logic [7:0] ra, rb;
      logic [67:0] e;
      int n, stall;
      if8.in_valid = 1'b0;
      if8.out_ready = 1'b1;
      if8.a = '0;
      if8.b = '0;
      if4.in_valid = 1'b0;
      if4.out_ready = 1'b1;
      if4.a = '0;
      if4.b = '0;
      #1;
      chk("reset in_ready", 64'(if8.in_ready), 64'd1);
      chk("reset out_valid", 64'(if8.out_valid), 64'd0);
      chk("reset diff", 64'(if8.diff), 64'd0);
      chk("reset borrow", 64'(if8.borrow), 64'd0);
      chk("reset zero", 64'(if8.zero), 64'd0);
      chk("reset ovf", 64'(if8.ovf), 64'd0);
      chk("reset out_valid w4", 64'(if4.out_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do8("basic 05-03", 8'h05, 8'h03);
      chk("basic diff const", 64'(if8.diff), 64'h02);
      do8("borrow 03-05", 8'h03, 8'h05);
      do8("ovf 80-01", 8'h80, 8'h01);
      do8("both 7F-FF", 8'h7F, 8'hFF);
      do8("zero A5-A5", 8'hA5, 8'hA5);
      do8("zero 00-00", 8'h00, 8'h00);
      for (int i = 0; i < 12; i++) do8("rand8", 8'($urandom), 8'($urandom));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if8.out_ready = 1'b0;
      start8(ra, rb);
      wait8();
      for (int i = 0; i < 5; i++) begin
         chk("stall out_valid", 64'(if8.out_valid), 64'd1);
         chk("stall in_ready", 64'(if8.in_ready), 64'd0);
         out8("stall", ra, rb);
         if8.in_valid = 1'b1;
         if8.a = 8'($urandom);
         if8.b = 8'($urandom);
         @(negedge clk);
      end
      if8.in_valid = 1'b0;
      out8("stall end", ra, rb);
      if8.out_ready = 1'b1;
      @(negedge clk);
      chk("release out_valid", 64'(if8.out_valid), 64'd0);
      chk("release in_ready", 64'(if8.in_ready), 64'd1);
      start8(8'h3C, 8'h11);
      @(negedge clk);
      if8.a = 8'h01;
      if8.b = 8'h02;
      if8.in_valid = 1'b1;
      repeat (2) @(negedge clk);
      if8.in_valid = 1'b0;
      wait8();
      out8("busy ignored", 8'h3C, 8'h11);
      @(negedge clk);
      chk("busy valid drop", 64'(if8.out_valid), 64'd0);
      start8(8'h10, 8'h01);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset out_valid", 64'(if8.out_valid), 64'd0);
      chk("midreset in_ready", 64'(if8.in_ready), 64'd1);
      chk("midreset diff", 64'(if8.diff), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do8("after reset 10-01", 8'h10, 8'h01);
      chk("after reset diff const", 64'(if8.diff), 64'h0F);
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            stall = $urandom_range(0, 1) ? int'($urandom_range(1, 3)) : 0;
            if4.out_ready = stall == 0;
            if4.a = 4'(a);
            if4.b = 4'(b);
            if4.in_valid = 1'b1;
            n = 0;
            while (!if4.in_ready && n < 50) begin
               @(negedge clk);
               n++;
            end
            @(negedge clk);
            if4.in_valid = 1'b0;
            n = 1;
            while (!if4.out_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            chk("sweep latency", 64'(n), 64'd5);
            out4("sweep", 4'(a), 4'(b));
            repeat (stall) @(negedge clk);
            if (stall != 0) begin
               e = model(4, a, b);
               chk("sweep stall diff", 64'(if4.diff), e[63:0]);
               chk("sweep stall valid", 64'(if4.out_valid), 64'd1);
            end
            if4.out_ready = 1'b1;
            @(negedge clk);
            chk("sweep valid drop", 64'(if4.out_valid), 64'd0);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
